// File: rtl/mgmt_gmii_tx_mac_if.sv
`default_nettype none
// ============================================================================
// mgmt_gmii_tx_mac_if : EthernetTxBus byte stream with tx_ready back-pressure
// Rev 1.0
// ============================================================================
interface mgmt_gmii_tx_mac_if;
  logic        start;
  logic        data_valid;
  logic [2:0]  bytes_valid;
  logic [31:0] data;
  logic        ready;

  modport master (output start, data_valid, bytes_valid, data, input ready);
  modport slave  (input start, data_valid, bytes_valid, data, output ready);
endinterface
`default_nettype wire

// File: rtl/mgmt_gmii_tx_mac.sv
`default_nettype none
// ============================================================================
// mgmt_gmii_tx_mac : byte stream to GMII (preamble/SFD, pad, FCS, IFG)
// Optional frame/byte counters enabled by macro MGMT_TX_MAC_STATS_EN.  Rev 1.0
// ============================================================================
module mgmt_gmii_tx_mac #(
  parameter int FIFO_DEPTH  = 16,
  parameter int IFG_CYCLES  = 12,
  parameter int MIN_PAYLOAD = 60
) (
  input  wire logic         tx_clk,
  input  wire logic         tx_rst_n,
  mgmt_gmii_tx_mac_if.slave tx_bus,
  output logic [7:0]        gmii_txd,
  output logic              gmii_tx_en,
  output logic              gmii_tx_er,
  output logic [2:0]        err_sticky
`ifdef MGMT_TX_MAC_STATS_EN
  ,
  output logic [31:0]       stat_frames,
  output logic [31:0]       stat_bytes
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IFG_W = $clog2(IFG_CYCLES + 1);
  localparam logic [10:0]      MIN_CNT = 11'(MIN_PAYLOAD);
  localparam logic [IFG_W-1:0] IFG_END = IFG_W'(IFG_CYCLES);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG
  } state_t;

  state_t           state;
  logic             tx_ready;
  logic [8:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full, fifo_clear;
  logic             wr_en, wr_last, rd_en;
  logic [8:0]       fifo_head;
  logic [7:0]       hold_data;
  logic             hold_valid, in_frame, start_accept, byte_in;
  logic [2:0]       phase_cnt;
  logic [10:0]      byte_cnt, byte_cnt_inc;
  logic [IFG_W-1:0] ifg_cnt;
  logic [31:0]      crc, fcs_word;
  logic             protocol_err, overflow_err, underrun_err;
  logic             unused_data_hi;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign tx_bus.ready   = tx_ready;
  assign unused_data_hi = ^tx_bus.data[31:8];

  assign start_accept = (state == IDLE) && tx_bus.start;
  assign byte_in      = tx_bus.data_valid && (in_frame || start_accept);
  // The FIFO only holds bytes of the frame in flight; anything arriving
  // while idle or in the gap (e.g. after an underrun) is flushed.
  assign fifo_clear   = (state == IDLE) || (state == IFG);
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign wr_en        = hold_valid && !fifo_clear;
  assign wr_last      = !(tx_bus.data_valid && in_frame);
  assign rd_en        = (state == DATA) && !fifo_empty;
  assign fifo_head    = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign byte_cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  assign fcs_word     = ~crc >> {phase_cnt[1:0], 3'b000};

  assign protocol_err = (tx_bus.start && (state != IDLE)) ||
                        (tx_bus.data_valid && (tx_bus.bytes_valid != 3'd1));
  assign overflow_err = wr_en && fifo_full;
  assign underrun_err = (state == DATA) && fifo_empty;

  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n || (fifo_clear && !start_accept)) begin
      hold_valid <= 1'b0;
      in_frame   <= 1'b0;
      hold_data  <= 8'h00;
    end else begin
      hold_valid <= byte_in;
      in_frame   <= byte_in;
      if (byte_in) hold_data <= tx_bus.data[7:0];
    end
  end

  always_ff @(posedge tx_clk) begin
    if (wr_en && !fifo_full) fifo_mem[wr_ptr[PTR_W-1:0]] <= {wr_last, hold_data};
  end

  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n || fifo_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !fifo_full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)               rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n) begin
      state       <= IDLE;
      tx_ready    <= 1'b1;
      gmii_txd    <= 8'h00;
      gmii_tx_en  <= 1'b0;
      gmii_tx_er  <= 1'b0;
      err_sticky  <= 3'b000;
      phase_cnt   <= 3'd0;
      byte_cnt    <= 11'd0;
      ifg_cnt     <= '0;
      crc         <= 32'hFFFF_FFFF;
`ifdef MGMT_TX_MAC_STATS_EN
      stat_frames <= 32'd0;
      stat_bytes  <= 32'd0;
`endif
    end else begin
      err_sticky <= err_sticky | {protocol_err, underrun_err, overflow_err};
      gmii_tx_er <= 1'b0;
      case (state)
        IDLE: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          tx_ready   <= 1'b1;
          if (tx_bus.start) begin
            state      <= PREAMBLE;
            tx_ready   <= 1'b0;
            gmii_txd   <= 8'h55;
            gmii_tx_en <= 1'b1;
            phase_cnt  <= 3'd1;
          end
        end
        PREAMBLE: begin
          gmii_txd   <= 8'h55;
          gmii_tx_en <= 1'b1;
          phase_cnt  <= phase_cnt + 3'd1;
          if (phase_cnt == 3'd6) state <= SFD;
        end
        SFD: begin
          gmii_txd   <= 8'hD5;
          gmii_tx_en <= 1'b1;
          crc        <= 32'hFFFF_FFFF;
          byte_cnt   <= 11'd0;
          state      <= DATA;
        end
        DATA: begin
          gmii_tx_en <= 1'b1;
          if (fifo_empty) begin
            gmii_txd   <= 8'h00;
            gmii_tx_er <= 1'b1;
            ifg_cnt    <= '0;
            state      <= IFG;
          end else begin
            gmii_txd <= fifo_head[7:0];
            crc      <= crc32_byte(crc, fifo_head[7:0]);
            byte_cnt <= byte_cnt_inc;
            if (fifo_head[8]) begin
              phase_cnt <= 3'd0;
              state     <= (byte_cnt_inc < MIN_CNT) ? PAD : FCS;
            end
          end
        end
        PAD: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b1;
          crc        <= crc32_byte(crc, 8'h00);
          byte_cnt   <= byte_cnt_inc;
          if (byte_cnt_inc >= MIN_CNT) begin
            phase_cnt <= 3'd0;
            state     <= FCS;
          end
        end
        FCS: begin
          gmii_txd   <= fcs_word[7:0];
          gmii_tx_en <= 1'b1;
          phase_cnt  <= phase_cnt + 3'd1;
          if (phase_cnt == 3'd3) begin
            ifg_cnt <= '0;
            state   <= IFG;
`ifdef MGMT_TX_MAC_STATS_EN
            stat_frames <= stat_frames + 32'd1;
            // Preamble + SFD + FCS add 12 bytes on the wire around the payload.
            stat_bytes  <= stat_bytes + 32'(byte_cnt) + 32'd12;
`endif
          end
        end
        IFG: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          if (ifg_cnt == IFG_END) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
          end else begin
            ifg_cnt <= ifg_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mgmt_gmii_tx_mac.sv
`default_nettype none
// ============================================================================
// tb_mgmt_gmii_tx_mac : scoreboard bench for the management GMII transmit MAC
// Rev 1.0
// ============================================================================
module tb_mgmt_gmii_tx_mac;

  logic        tx_clk   = 1'b0;
  logic        tx_rst_n = 1'b0;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic [2:0]  err_sticky;
`ifdef MGMT_TX_MAC_STATS_EN
  logic [31:0] stat_frames;
  logic [31:0] stat_bytes;
`endif

  mgmt_gmii_tx_mac_if tx_bus();

  mgmt_gmii_tx_mac dut (
    .tx_clk     (tx_clk),
    .tx_rst_n   (tx_rst_n),
    .tx_bus     (tx_bus),
    .gmii_txd   (gmii_txd),
    .gmii_tx_en (gmii_tx_en),
    .gmii_tx_er (gmii_tx_er),
    .err_sticky (err_sticky)
`ifdef MGMT_TX_MAC_STATS_EN
    ,
    .stat_frames(stat_frames),
    .stat_bytes (stat_bytes)
`endif
  );

  always #4 tx_clk = ~tx_clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [8:0] exp_q [$];
  logic [7:0] rx_q [$];
  int         en_cnt = 0;
  int         last_len = 0;
  int         fall_cyc = 0;
  int         rise_cyc = 0;
  bit         prev_en = 1'b0;
  bit         prev_ready = 1'b1;

  always @(posedge tx_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bit-serial reflected CRC-32, used both for the FCS model and the residue.
  function automatic logic [31:0] crc_bit(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int j = 0; j < 8; j++) begin
      if (c[0] ^ d[j]) c = (c >> 1) ^ 32'hEDB8_8320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  always @(negedge tx_clk) begin
    if (!tx_rst_n) begin
      en_cnt     = 0;
      prev_en    = 1'b0;
      prev_ready = 1'b1;
    end else begin
      if (gmii_tx_en) begin
        if (en_cnt == 0) rx_q.delete();
        en_cnt++;
        if (en_cnt > 8 && !gmii_tx_er) rx_q.push_back(gmii_txd);
        if (exp_q.size() == 0) check("sb_extra", exp_q.size(), 1);
        else check("txd", {23'h0, gmii_tx_er, gmii_txd}, {23'h0, exp_q.pop_front()});
      end else if (prev_en) begin
        last_len = en_cnt;
        en_cnt   = 0;
        fall_cyc = cyc;
      end
      if (tx_bus.ready && !prev_ready) rise_cyc = cyc;
      prev_en    = gmii_tx_en;
      prev_ready = tx_bus.ready;
    end
  end

  // Pushes the expected wire image, then drives n framed bytes (n == 0 gives
  // a start pulse with no data), optionally followed by a gap and unframed
  // bytes, or aborted by a reset pulse at byte index abort_at.
  task automatic drive_frame(input int n, input int tail, input int abort_at, input bit incr);
    logic [7:0]  pl [];
    logic [7:0]  b;
    logic [31:0] c;
    int          plen;
    pl = new[n];
    for (int i = 0; i < n; i++) pl[i] = incr ? 8'(i) : 8'($urandom_range(0, 255));
    repeat (7) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
    if (n == 0) begin
      exp_q.push_back(9'h100);
    end else begin
      c    = 32'hFFFF_FFFF;
      plen = (n < 60) ? 60 : n;
      for (int i = 0; i < plen; i++) begin
        b = (i < n) ? pl[i] : 8'h00;
        exp_q.push_back({1'b0, b});
        c = crc_bit(c, b);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, c[8*k +: 8]});
    end
    for (int i = 0; i < ((n == 0) ? 1 : n); i++) begin
      if (i == abort_at) begin
        tx_rst_n          = 1'b0;
        tx_bus.start      = 1'b0;
        tx_bus.data_valid = 1'b0;
        @(posedge tx_clk); #1;
        check("rst_mid_tx_en", {31'h0, gmii_tx_en}, 32'h0);
        check("rst_mid_ready", {31'h0, tx_bus.ready}, 32'h1);
        check("rst_mid_err", {29'h0, err_sticky}, 32'h0);
        exp_q.delete();
        tx_rst_n = 1'b1;
        return;
      end
      tx_bus.start      = (i == 0);
      tx_bus.data_valid = (n > 0);
      tx_bus.data       = {24'($urandom()), (n > 0) ? pl[i] : 8'h00};
      @(posedge tx_clk); #1;
    end
    tx_bus.start      = 1'b0;
    tx_bus.data_valid = 1'b0;
    if (tail > 0) begin
      @(posedge tx_clk); #1;
      for (int i = 0; i < tail; i++) begin
        tx_bus.data_valid = 1'b1;
        tx_bus.data       = $urandom();
        @(posedge tx_clk); #1;
      end
      tx_bus.data_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(tx_bus.ready && exp_q.size() == 0 && !gmii_tx_en) && k < 400) begin
      @(posedge tx_clk); #1;
      k++;
    end
    check("idle_timeout", {31'h0, tx_bus.ready}, 32'h1);
  endtask

  task automatic finish_frame(input string name, input int exp_len,
                              input logic [2:0] exp_err, input bit chk_res);
    logic [31:0] c;
    wait_idle();
    @(negedge tx_clk); #1;
    check({name, "_len"}, last_len, exp_len);
    check({name, "_ifg"}, rise_cyc - fall_cyc, 12);
    check({name, "_err"}, {29'h0, err_sticky}, {29'h0, exp_err});
    check({name, "_sb_left"}, exp_q.size(), 0);
    if (chk_res) begin
      c = 32'hFFFF_FFFF;
      foreach (rx_q[i]) c = crc_bit(c, rx_q[i]);
      check({name, "_residue"}, c, 32'hDEBB_20E3);
    end
  endtask

  initial begin
    tx_bus.start       = 1'b0;
    tx_bus.data_valid  = 1'b0;
    tx_bus.bytes_valid = 3'd1;
    tx_bus.data        = 32'h0;
    tx_rst_n           = 1'b0;
    repeat (3) @(posedge tx_clk);
    #1;
    check("reset_ready", {31'h0, tx_bus.ready}, 32'h1);
    check("reset_txd", {24'h0, gmii_txd}, 32'h0);
    check("reset_tx_en", {31'h0, gmii_tx_en}, 32'h0);
    check("reset_tx_er", {31'h0, gmii_tx_er}, 32'h0);
    check("reset_err", {29'h0, err_sticky}, 32'h0);
    tx_rst_n = 1'b1;
    @(posedge tx_clk); #1;

    drive_frame(64, 0, -1, 1'b1);
    finish_frame("f64", 76, 3'b000, 1'b1);

    drive_frame(10, 0, -1, 1'b0);
    finish_frame("f10", 72, 3'b000, 1'b1);

    drive_frame(20, 44, -1, 1'b0);
    finish_frame("gap20", 72, 3'b000, 1'b1);

    drive_frame(64, 0, -1, 1'b0);
    begin
      int k = 0;
      while (en_cnt != 73 && k < 200) begin
        @(negedge tx_clk); #1;
        k++;
      end
    end
    check("fcs_start_sync", en_cnt, 73);
    tx_bus.start = 1'b1;
    @(posedge tx_clk); #1;
    tx_bus.start = 1'b0;
    check("fcs_start_ready", {31'h0, tx_bus.ready}, 32'h0);
    finish_frame("fcs_start", 76, 3'b100, 1'b1);

    drive_frame(64, 0, 30, 1'b0);
    drive_frame(60, 0, -1, 1'b0);
    finish_frame("after_rst", 72, 3'b000, 1'b1);

    drive_frame(0, 0, -1, 1'b0);
    finish_frame("underrun", 9, 3'b010, 1'b0);

`ifdef MGMT_TX_MAC_STATS_EN
    tx_rst_n = 1'b0;
    @(posedge tx_clk); #1;
    tx_rst_n = 1'b1;
    @(posedge tx_clk); #1;
    drive_frame(64, 0, -1, 1'b0);
    finish_frame("st64", 76, 3'b000, 1'b1);
    drive_frame(10, 0, -1, 1'b0);
    finish_frame("st10", 72, 3'b000, 1'b1);
    check("stat_frames", stat_frames, 32'd2);
    check("stat_bytes", stat_bytes, 32'd148);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
